// File: rtl/regbank_pkg.sv
// Shared register-bank definitions: bank geometry and the destination decoder
// used both by the write arbiter and by the bank itself.
package regbank_pkg;

   localparam int NUM_REGS = 16;
   localparam int DEST_W   = 4;

   function automatic logic [NUM_REGS-1:0] dest_to_onehot(input logic [DEST_W-1:0] dest);
      return NUM_REGS'(1) << dest;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from i_ptr upward (wrapping) and
// grants the first active request unless i_stall blocks this cycle.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_ptr,
   input  logic               i_stall,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [PTR_W-1:0]   o_winner
);

   logic w_found;

   // Scan from the farthest offset down to ptr so the nearest request overwrites the rest.
   always_comb begin
      o_winner = '0;
      o_gnt    = '0;
      w_found  = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (i_req[(int'(i_ptr) + k) % NUM_REQ]) begin
            o_winner = PTR_W'((int'(i_ptr) + k) % NUM_REQ);
            w_found  = 1'b1;
         end
      end
      if (w_found && !i_stall) begin
         o_gnt[o_winner] = 1'b1;
      end
   end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Round-robin arbiter sharing the register bank's single write port.
// Optional macro R0_HARDWIRED_EN: register 0 reads as zero, so writes to it are dropped.
module regbank_write_arbiter
   import regbank_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req,
   input  logic [NUM_REQ*DEST_W-1:0]  dest_in,
   input  logic [NUM_REQ*DATA_W-1:0]  data_in,
   input  logic                       stall,
   output logic [NUM_REQ-1:0]         gnt,
   output logic [NUM_REGS-1:0]        enable,
   output logic [DEST_W-1:0]          wr_dest,
   output logic [DATA_W-1:0]          wr_data,
   output logic                       wr_valid
);

   localparam int PTR_W = $clog2(NUM_REQ);

   logic [PTR_W-1:0]    r_ptr;
   logic [NUM_REGS-1:0] r_enable;
   logic [DEST_W-1:0]   r_dest;
   logic [DATA_W-1:0]   r_data;
   logic                r_valid;

   logic [NUM_REQ-1:0]  w_gnt;
   logic [PTR_W-1:0]    w_winner;
   logic                w_grant;
   logic                w_writeEn;
   logic [DEST_W-1:0]   w_selDest;
   logic [DATA_W-1:0]   w_selData;

   // Reset blocks grants the same way stall does, so gnt is low while rst is held.
   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .i_stall  (stall | rst),
      .o_gnt    (w_gnt),
      .o_winner (w_winner)
   );

   assign w_grant = |w_gnt;

   always_comb begin
      w_selDest = '0;
      w_selData = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_gnt[i]) begin
            w_selDest = dest_in[i*DEST_W +: DEST_W];
            w_selData = data_in[i*DATA_W +: DATA_W];
         end
      end
   end

`ifdef R0_HARDWIRED_EN
   // A write to r0 still consumes its grant but never reaches the bank.
   assign w_writeEn = w_grant && (w_selDest != '0);
`else
   assign w_writeEn = w_grant;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr    <= '0;
         r_enable <= '0;
         r_dest   <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
      end else begin
         if (w_grant) begin
            if (w_winner == PTR_W'(NUM_REQ - 1)) begin
               r_ptr <= '0;
            end else begin
               r_ptr <= w_winner + PTR_W'(1);
            end
         end
         if (w_writeEn) begin
            r_enable <= dest_to_onehot(w_selDest);
            r_dest   <= w_selDest;
            r_data   <= w_selData;
            r_valid  <= 1'b1;
         end else begin
            r_enable <= '0;
            r_valid  <= 1'b0;
         end
      end
   end

   assign gnt      = w_gnt;
   assign enable   = r_enable;
   assign wr_dest  = r_dest;
   assign wr_data  = r_data;
   assign wr_valid = r_valid;

endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Round-robin write-port arbiter for the 16-entry register bank. Up to NUM_REQ producers (ALU, load unit, move unit, and so on) present a destination register number and data. Each cycle the block grants at most one producer and drives a registered one-hot write enable, destination and data to the bank. Producers therefore share the bank's single write port without collisions, and the bank receives the same one-hot enable format as its destination decoder with one cycle of latency.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8
- DATA_W, 16: register data width

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req  in  NUM_REQ  per-requester write request; held until granted
- dest_in  in  NUM_REQ*4  flattened destination numbers; requester i uses bits [4i+3:4i]
- data_in  in  NUM_REQ*DATA_W  flattened write data; requester i uses bits [DATA_W*i +: DATA_W]
- stall  in  1  bank busy; blocks all grants in the current cycle
- gnt  out  NUM_REQ  combinational one-hot grant; the transfer completes at the edge where req[i] and gnt[i] are both high
- enable  out  16  registered one-hot register write enable
- wr_dest  out  4  registered destination of the last accepted write
- wr_data  out  DATA_W  registered data of the last accepted write
- wr_valid  out  1  registered; high for the one cycle in which enable is non-zero

## Operation
- Arbitration is round-robin. The pointer ptr (width clog2(NUM_REQ)) is the highest-priority index. The search runs ptr, ptr+1, …, wrapping modulo NUM_REQ, and the first index with req high wins.
- gnt[i] is high only if i wins, stall is 0 and rst is 0. At most one bit of gnt is set at any time.
- On an edge with a grant to requester i:
  - enable becomes 1<<dest_in[i]
  - wr_dest becomes dest_in[i]
  - wr_data becomes data_in[i]
  - wr_valid becomes 1
  - ptr becomes (i+1) mod NUM_REQ
- On an edge with no grant (no request, or stall):
  - enable becomes 0 and wr_valid becomes 0
  - wr_dest and wr_data hold their values
  - ptr holds
- A requester samples gnt in the same cycle. After the transfer it drops req or presents the next payload; a request that stays high is a new request.
- Two requesters targeting the same register in the same cycle are serialised in round-robin order. The later write wins in the bank, and the block adds no ordering beyond that.
- dest_in and data_in of a requester whose req is low are ignored.

## Timing
- Reset values: enable=0, wr_valid=0, wr_dest=0, wr_data=0, ptr=0. gnt=0 while rst is high.
- Reset in mid-operation clears everything asynchronously. Requests are re-arbitrated starting from index 0 on the first edge after rst falls, and no write is lost or duplicated beyond the requester's retry.
- Latency: 1 cycle from the granting edge to enable and wr_valid at the bank.
- Throughput: 1 write per cycle with no bubble when requests are continuous.
- Fairness: a requester that holds req is granted within NUM_REQ non-stalled cycles.
- stall is purely combinational into gnt and has no registered effect beyond suppressing the update.
- Pointer wrap: after a grant to index NUM_REQ-1, ptr becomes 0.

## Configuration
- Macro R0_HARDWIRED_EN:
  - When defined, register 0 is hardwired to zero. A request with dest_in=0 is still granted and ptr still advances, but the output edge produces enable=0 and wr_valid=0, and wr_dest and wr_data hold their values.
  - When undefined, dest 0 is written like any other register.

## Structure
- Shared package regbank_pkg holds:
  - NUM_REGS=16
  - DEST_W=4
  - the one-hot decode function dest_to_onehot(dest), used here and by the bank
- One sub-module, rr_arbiter, is natural. Its inputs are NUM_REQ, req, ptr and stall; its output is the one-hot gnt together with the winner index. The top-level block holds ptr and the output registers.

## Test plan
- Reset, then req=0 for 3 cycles -> gnt=0, enable=0, wr_valid=0, wr_dest=0, wr_data=0 throughout.
- Single request: req=0001, dest_in[0]=5, data_in[0]=0x1234 for 1 cycle -> gnt=0001 that cycle; next cycle enable=0x0020, wr_dest=5, wr_data=0x1234, wr_valid=1; the cycle after, enable=0.
- All four requesting continuously with dests 1,2,3,4 -> grant order 0,1,2,3,0,…; enable sequence 0x0002, 0x0004, 0x0008, 0x0010, repeating, with no idle cycles.
- stall=1 for 2 cycles with req=0110 -> gnt=0 and enable=0 for both cycles; after stall falls, requester 1 is granted first, then requester 2.
- rst asserted mid-stream, just after requester 2 is granted (ptr=3) -> outputs are 0 immediately; after release with req=1001, requester 0 is granted first.
- R0_HARDWIRED_EN defined, req=0001 with dest_in[0]=0 -> gnt=0001, next-cycle enable=0 and wr_valid=0, and ptr has advanced to 1. With the macro undefined, the same stimulus gives enable=0x0001.
